// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/bubble/flush control.
// Define EX_MEM_MADD_EN to keep the multi-cycle madd/msub partial product and counter.
module ex_mem_reg #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int CNT_W   = 2,
   parameter int STALL_W = 6,
   parameter int EX_IDX  = 3,
   parameter int MEM_IDX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STALL_W-1:0]  stall,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   ex_wd,
   input  logic                ex_wreg,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic [DATA_W-1:0]   ex_hi,
   input  logic [DATA_W-1:0]   ex_lo,
   input  logic                ex_whilo,
   input  logic [2*DATA_W-1:0] hilo_temp_i,
   input  logic [CNT_W-1:0]    cnt_i,
   output logic [ADDR_W-1:0]   mem_wd,
   output logic                mem_wreg,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_hi,
   output logic [DATA_W-1:0]   mem_lo,
   output logic                mem_whilo,
   output logic [2*DATA_W-1:0] hilo_temp_o,
   output logic [CNT_W-1:0]    cnt_o
);

   logic w_ex_stall;
   logic w_mem_stall;
   logic w_bubble;
   logic w_hold;

   logic [ADDR_W-1:0] r_wd;
   logic              r_wreg;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic              r_whilo;

   assign w_ex_stall  = stall[EX_IDX];
   assign w_mem_stall = stall[MEM_IDX];
   // Execute-stalled-only-memory-running means a bubble; EX stalled with MEM free never holds.
   assign w_bubble    = w_ex_stall & ~w_mem_stall;
   assign w_hold      = w_ex_stall &  w_mem_stall;

   // Result registers: flush beats stall; bubble zeroes every write enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wd    <= {ADDR_W{1'b0}};
         r_wreg  <= 1'b0;
         r_wdata <= {DATA_W{1'b0}};
         r_hi    <= {DATA_W{1'b0}};
         r_lo    <= {DATA_W{1'b0}};
         r_whilo <= 1'b0;
      end else if (flush || w_bubble) begin
         r_wd    <= {ADDR_W{1'b0}};
         r_wreg  <= 1'b0;
         r_wdata <= {DATA_W{1'b0}};
         r_hi    <= {DATA_W{1'b0}};
         r_lo    <= {DATA_W{1'b0}};
         r_whilo <= 1'b0;
      end else if (w_hold) begin
         r_wd    <= r_wd;
         r_wreg  <= r_wreg;
         r_wdata <= r_wdata;
         r_hi    <= r_hi;
         r_lo    <= r_lo;
         r_whilo <= r_whilo;
      end else begin
         r_wd    <= ex_wd;
         r_wreg  <= ex_wreg;
         r_wdata <= ex_wdata;
         r_hi    <= ex_hi;
         r_lo    <= ex_lo;
         r_whilo <= ex_whilo;
      end
   end

   assign mem_wd    = r_wd;
   assign mem_wreg  = r_wreg;
   assign mem_wdata = r_wdata;
   assign mem_hi    = r_hi;
   assign mem_lo    = r_lo;
   assign mem_whilo = r_whilo;

`ifdef EX_MEM_MADD_EN
   logic [2*DATA_W-1:0] r_hilo_temp;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_unused;

   // Partial product survives any execute stall so madd/msub can resume.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hilo_temp <= {(2*DATA_W){1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
      end else if (flush) begin
         r_hilo_temp <= {(2*DATA_W){1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
      end else if (w_ex_stall) begin
         r_hilo_temp <= hilo_temp_i;
         r_cnt       <= cnt_i;
      end else begin
         r_hilo_temp <= {(2*DATA_W){1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
      end
   end

   assign hilo_temp_o = r_hilo_temp;
   assign cnt_o       = r_cnt;
   assign w_unused    = ^stall;
`else
   logic w_unused;

   assign hilo_temp_o = {(2*DATA_W){1'b0}};
   assign cnt_o       = {CNT_W{1'b0}};
   assign w_unused    = ^{stall, hilo_temp_i, cnt_i};
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus pushes expected outputs, a monitor pops and compares.
module tb_ex_mem_reg;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        whilo;
      logic [63:0] ht;
      logic [1:0]  cnt;
   } exp_t;

`ifdef EX_MEM_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [31:0] ex_hi;
   logic [31:0] ex_lo;
   logic        ex_whilo;
   logic [63:0] hilo_temp_i;
   logic [1:0]  cnt_i;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic        mem_whilo;
   logic [63:0] hilo_temp_o;
   logic [1:0]  cnt_o;

   int errors = 0;
   int checks = 0;
   exp_t  sb_q[$];
   string nm_q[$];

   ex_mem_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
      .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                               input logic [63:0] ht, input logic [1:0] cnt);
      exp_t e;
      e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.hi = hi; e.lo = lo; e.whilo = whilo;
      e.ht  = MADD ? ht  : 64'h0;
      e.cnt = MADD ? cnt : 2'd0;
      return e;
   endfunction

   task automatic compare(input string nm, input exp_t e);
      exp_t a;
      a = '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got wd=%0d wreg=%b wdata=%h hi=%h lo=%h whilo=%b ht=%h cnt=%0d, want wd=%0d wreg=%b wdata=%h hi=%h lo=%h whilo=%b ht=%h cnt=%0d",
                  nm, a.wd, a.wreg, a.wdata, a.hi, a.lo, a.whilo, a.ht, a.cnt,
                  e.wd, e.wreg, e.wdata, e.hi, e.lo, e.whilo, e.ht, e.cnt);
      end
   endtask

   // Monitor: one registered result per edge, compared shortly after the edge.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() != 0) compare(nm_q.pop_front(), sb_q.pop_front());
   end

   task automatic step(input string nm, input exp_t e);
      sb_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
      ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
   endtask

   exp_t zero_e;

   initial begin
      zero_e = mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
      rst = 1'b0; stall = 6'b000000; flush = 1'b0;
      set_ex(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      hilo_temp_i = 64'h0; cnt_i = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Plain transfer
      set_ex(5'd7, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1);
      step("transfer", mk(5'd7, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0));

      // Asynchronous reset between edges, held for two edges
      ex_wdata = 32'hDEADBEEF;
      rst = 1'b0;
      #1;
      compare("reset_async", zero_e);
      step("reset_edge1", zero_e);
      step("reset_edge2", zero_e);
      rst = 1'b1;

      set_ex(5'd7, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1);
      step("transfer2", mk(5'd7, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0));

      // Bubble keeps partial product, zeroes results
      stall = 6'b001111; hilo_temp_i = 64'h1_0000_0002; cnt_i = 2'd1;
      step("bubble", mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h1_0000_0002, 2'd1));

      stall = 6'b000000;
      set_ex(5'd3, 1'b1, 32'h55, 32'h1111, 32'h2222, 1'b0);
      step("resume", mk(5'd3, 1'b1, 32'h55, 32'h1111, 32'h2222, 1'b0, 64'h0, 2'd0));

      // Hold for three edges while execute inputs keep changing
      stall = 6'b011111;
      set_ex(5'd10, 1'b0, 32'h99, 32'h0, 32'hFFFF, 1'b1);
      hilo_temp_i = 64'hCAFE_0000_0000_0001; cnt_i = 2'd2;
      step("hold1", mk(5'd3, 1'b1, 32'h55, 32'h1111, 32'h2222, 1'b0, 64'hCAFE_0000_0000_0001, 2'd2));
      set_ex(5'd11, 1'b1, 32'hAAAA, 32'h5, 32'h6, 1'b0);
      hilo_temp_i = 64'hCAFE_0000_0000_0002; cnt_i = 2'd3;
      step("hold2", mk(5'd3, 1'b1, 32'h55, 32'h1111, 32'h2222, 1'b0, 64'hCAFE_0000_0000_0002, 2'd3));
      set_ex(5'd12, 1'b0, 32'hBBBB, 32'h7, 32'h8, 1'b1);
      hilo_temp_i = 64'hCAFE_0000_0000_0003; cnt_i = 2'd0;
      step("hold3", mk(5'd3, 1'b1, 32'h55, 32'h1111, 32'h2222, 1'b0, 64'hCAFE_0000_0000_0003, 2'd0));

      // Flush overrides a hold
      flush = 1'b1;
      hilo_temp_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd3;
      step("flush_over_stall", zero_e);
      flush = 1'b0; stall = 6'b000000;

      // All-ones data and top register address pass unmodified
      set_ex(5'd31, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
      step("transfer_max", mk(5'd31, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 64'h0, 2'd0));

      // Memory stalled without execute: treated as a transfer
      stall = 6'b010000;
      set_ex(5'd1, 1'b1, 32'h80000001, 32'h12, 32'h34, 1'b0);
      step("illegal_as_xfer", mk(5'd1, 1'b1, 32'h80000001, 32'h12, 32'h34, 1'b0, 64'h0, 2'd0));

      stall = 6'b000000; flush = 1'b1;
      step("flush_plain", zero_e);
      flush = 1'b0;

      // Reset mid-madd discards partial product
      stall = 6'b001111; hilo_temp_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd3;
      step("bubble2", mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd3));
      rst = 1'b0;
      #1;
      compare("reset_mid_madd", zero_e);
      step("reset_mid_edge", zero_e);
      rst = 1'b1; stall = 6'b000000;
      set_ex(5'd4, 1'b1, 32'h4444, 32'h0, 32'h0, 1'b0);
      step("after_reset", mk(5'd4, 1'b1, 32'h4444, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0));

      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d results never compared, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
